// File: rtl/reg_file_sb.sv
// 32-entry register file with a per-register busy scoreboard and pending-write counter.
// Define REGFILE_BYPASS_EN to forward the write-back data and busy clear to same-cycle reads.
module reg_file_sb #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite,
    input  logic [4:0]       writeReg,
    input  logic [WIDTH-1:0] writeData,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    input  logic             issueValid,
    input  logic [4:0]       issueReg,
    output logic             rsBusy,
    output logic             rtBusy,
    output logic [5:0]       pendingCount
);

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;
    logic [5:0]       pending_count_q;
    logic [5:0]       pending_count_d;

    logic wr_en;
    logic iss_en;
    logic set_new;
    logic clr_old;

    always_comb begin
        wr_en  = RegWrite && (writeReg != 5'd0);
        iss_en = issueValid && (issueReg != 5'd0);

        regs_d = regs_q;
        if (wr_en) begin
            regs_d[writeReg] = writeData;
        end
        regs_d[0] = '0;

        // Clear before set so a newer in-flight writer to the same register wins.
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[writeReg] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issueReg] = 1'b1;
        end
        busy_d[0] = 1'b0;

        set_new = iss_en && !busy_q[issueReg];
        clr_old = wr_en && busy_q[writeReg] && !(iss_en && (issueReg == writeReg));

        pending_count_d = pending_count_q;
        if (set_new && !clr_old) begin
            pending_count_d = pending_count_q + 6'd1;
        end else if (clr_old && !set_new) begin
            pending_count_d = pending_count_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            busy_q          <= '0;
            pending_count_q <= '0;
        end else begin
            regs_q          <= regs_d;
            busy_q          <= busy_d;
            pending_count_q <= pending_count_d;
        end
    end

    always_comb begin
        readData1 = regs_q[rs];
        readData2 = regs_q[rt];
        rsBusy    = busy_q[rs];
        rtBusy    = busy_q[rt];
`ifdef REGFILE_BYPASS_EN
        // Forwarded reads stay busy only if a newer writer issues in the same cycle.
        if (!rst && wr_en && (writeReg == rs)) begin
            readData1 = writeData;
            rsBusy    = iss_en && (issueReg == rs);
        end
        if (!rst && wr_en && (writeReg == rt)) begin
            readData2 = writeData;
            rtBusy    = iss_en && (issueReg == rt);
        end
`endif
    end

    assign pendingCount = pending_count_q;

endmodule
